// File: rtl/digit_serial_subtractor_pkg.sv
// Shared definitions for the digit-serial subtractor: FSM encodings, default
// geometry and helpers that derive the digit count and counter width.
package digit_serial_subtractor_pkg;

   localparam int DEF_WIDTH = 16;
   localparam int DEF_DIGIT = 4;

   typedef logic [1:0] state_t;

   localparam state_t ST_IDLE = 2'd0;
   localparam state_t ST_RUN  = 2'd1;
   localparam state_t ST_DONE = 2'd2;

   function automatic int ndig_of(input int width, input int digit);
      return width / digit;
   endfunction

   // A single-digit operation still needs one counter bit to exist.
   function automatic int cnt_width(input int ndig);
      return (ndig > 1) ? $clog2(ndig) : 1;
   endfunction

endpackage

// File: rtl/digit_serial_subtractor_digit_sub.sv
// DIGIT-wide combinational subtract with borrow: a ripple of full-adder cells
// computing a + ~b + ~bin, so the carry chain carries the inverted borrow.
module digit_sub
   import digit_serial_subtractor_pkg::*;
#(
   parameter int DIGIT = DEF_DIGIT
) (
   input  logic [DIGIT-1:0] a_dig,
   input  logic [DIGIT-1:0] b_dig,
   input  logic             bin,
   output logic [DIGIT-1:0] d,
   output logic             bout
);

   logic [DIGIT:0]   carry;
   logic [DIGIT-1:0] b_inv;

   assign b_inv    = ~b_dig;
   assign carry[0] = ~bin;

   for (genvar i = 0; i < DIGIT; i++) begin : g_fa
      assign d[i]       = a_dig[i] ^ b_inv[i] ^ carry[i];
      assign carry[i+1] = (a_dig[i] & b_inv[i]) | (carry[i] & (a_dig[i] ^ b_inv[i]));
   end

   assign bout = ~carry[DIGIT];

endmodule

// File: rtl/digit_serial_subtractor.sv
// Multi-cycle subtractor: diff = a - b - bin, DIGIT bits per clock, LSB digit
// first, with the running borrow held in a flop between digits.
module digit_serial_subtractor
   import digit_serial_subtractor_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int DIGIT = DEF_DIGIT
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   output logic             ready,
   output logic [WIDTH-1:0] diff,
   output logic             bout,
   output logic             ovf,
   output logic             done
);

   localparam int NDIG  = ndig_of(WIDTH, DIGIT);
   localparam int CNT_W = cnt_width(NDIG);

   state_t            state;
   logic [CNT_W-1:0]  cnt;
   logic              borrow;
   logic [WIDTH-1:0]  a_sr;
   logic [WIDTH-1:0]  b_sr;
   logic [WIDTH-1:0]  res_sr;
   logic              a_msb;
   logic              b_msb;

   logic [DIGIT-1:0]  dig_d;
   logic              dig_bout;
   logic              accept;
   logic              running;
   logic              last_dig;
   logic [WIDTH-1:0]  res_next;

   assign ready    = (state != ST_RUN);
   assign done     = (state == ST_DONE);
   assign accept   = start & ready;
   assign running  = (state == ST_RUN);
   assign last_dig = running && (cnt == CNT_W'(NDIG - 1));

   digit_sub #(
      .DIGIT (DIGIT)
   ) u_digit_sub (
      .a_dig (a_sr[DIGIT-1:0]),
      .b_dig (b_sr[DIGIT-1:0]),
      .bin   (borrow),
      .d     (dig_d),
      .bout  (dig_bout)
   );

   // New digit enters at the top so after NDIG shifts the LSB digit sits at bit 0.
   assign res_next = (res_sr >> DIGIT) | (WIDTH'(dig_d) << (WIDTH - DIGIT));

   // Control and architectural outputs: FSM, digit counter, borrow, result ports.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= ST_IDLE;
         cnt    <= '0;
         borrow <= 1'b0;
         diff   <= '0;
         bout   <= 1'b0;
         ovf    <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: if (start) state <= ST_RUN;
            ST_RUN:  if (last_dig) state <= ST_DONE;
            ST_DONE: state <= start ? ST_RUN : ST_IDLE;
            default: state <= ST_IDLE;
         endcase

         if (accept) begin
            cnt    <= '0;
            borrow <= bin;
         end else if (running) begin
            cnt    <= cnt + 1'b1;
            borrow <= dig_bout;
         end

         if (last_dig) begin
            diff <= res_next;
            bout <= dig_bout;
            ovf  <= (a_msb != b_msb) && (res_next[WIDTH-1] != a_msb);
         end
      end
   end

   // Operand and partial-result shift registers carry no reset: every digit is
   // rewritten before it can reach diff.
   always_ff @(posedge clk) begin
      if (accept) begin
         a_sr  <= a;
         b_sr  <= b;
         a_msb <= a[WIDTH-1];
         b_msb <= b[WIDTH-1];
      end else if (running) begin
         a_sr   <= a_sr >> DIGIT;
         b_sr   <= b_sr >> DIGIT;
         res_sr <= res_next;
      end
   end

endmodule
